// File: rtl/i2c_line_sampler.sv
// i2c_line_sampler: synchronises and glitch-filters SCL/SDA, detects edges/START/STOP
// and shifts in bytes plus the ACK bit for the slave protocol FSM.
module i2c_line_sampler #(
  parameter int DIV_SAMPLE = 100,
  parameter int FILT_LEN   = 3
) (
  input  logic       clk_i,
  input  logic       rstn,
  input  logic       clk_en,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_f,
  output logic       sda_f,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy,
  output logic [3:0] bit_cnt,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ack
);
  localparam int CW = DIV_SAMPLE > 1 ? $clog2(DIV_SAMPLE) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV_SAMPLE - 1);
  localparam logic [3:0] FL = 4'(FILT_LEN);
  typedef enum logic [1:0] {IDLE, RECV, ACK} state_t;
  logic [1:0] s1, s2, filt, prev;
  logic [1:0][3:0] agree;
  logic [CW-1:0] cnt;
  logic tick;
  state_t state, state_n;
  logic [3:0] cnt_n;
  logic [6:0] sh, sh_n;
  logic [7:0] byte_n;
  logic valid_n, ack_n, busy_n;
  assign tick = clk_en && (cnt == DIV_LAST);
  assign scl_f = filt[0];
  assign sda_f = filt[1];
  // index 0 is SCL, index 1 is SDA
  always_ff @(posedge clk_i or negedge rstn)
    if (!rstn) begin
      s1 <= '1;
      s2 <= '1;
      filt <= '1;
      prev <= '1;
      agree <= '0;
      cnt <= '0;
    end else begin
      s1 <= {sda_i, scl_i};
      s2 <= s1;
      prev <= filt;
      cnt <= (!clk_en || tick) ? '0 : cnt + 1'b1;
      for (int i = 0; i < 2; i++)
        if (!clk_en) agree[i] <= '0;
        else if (tick) begin
          if (s2[i] == filt[i]) agree[i] <= '0;
          else if (agree[i] + 4'd1 == FL) begin
            filt[i] <= ~filt[i];
            agree[i] <= '0;
          end else agree[i] <= agree[i] + 4'd1;
        end
    end
  // START/STOP need SCL high on both sides of the SDA change
  always_ff @(posedge clk_i or negedge rstn)
    if (!rstn) begin
      scl_rise <= 1'b0;
      scl_fall <= 1'b0;
      start_det <= 1'b0;
      stop_det <= 1'b0;
    end else begin
      scl_rise <= filt[0] & ~prev[0];
      scl_fall <= ~filt[0] & prev[0];
      start_det <= prev[0] & filt[0] & prev[1] & ~filt[1];
      stop_det <= prev[0] & filt[0] & ~prev[1] & filt[1];
    end
  always_comb begin
    state_n = state;
    cnt_n = bit_cnt;
    sh_n = sh;
    byte_n = rx_byte;
    valid_n = 1'b0;
    ack_n = rx_ack;
    busy_n = stop_det ? 1'b0 : start_det ? 1'b1 : bus_busy;
    if (stop_det) begin
      state_n = IDLE;
      cnt_n = '0;
    end else if (start_det) begin
      state_n = RECV;
      cnt_n = '0;
    end else if (scl_rise && state == RECV) begin
      sh_n = {sh[5:0], sda_f};
      cnt_n = bit_cnt + 4'd1;
      if (bit_cnt == 4'd7) begin
        byte_n = {sh, sda_f};
        valid_n = 1'b1;
        state_n = ACK;
      end
    end else if (scl_rise && state == ACK) begin
      ack_n = sda_f;
      cnt_n = '0;
      state_n = RECV;
    end
  end
  always_ff @(posedge clk_i or negedge rstn)
    if (!rstn) begin
      state <= IDLE;
      bit_cnt <= '0;
      sh <= '0;
      rx_byte <= '0;
      rx_valid <= 1'b0;
      rx_ack <= 1'b1;
      bus_busy <= 1'b0;
    end else begin
      state <= state_n;
      bit_cnt <= cnt_n;
      sh <= sh_n;
      rx_byte <= byte_n;
      rx_valid <= valid_n;
      rx_ack <= ack_n;
      bus_busy <= busy_n;
    end
endmodule

// File: tb/tb_i2c_line_sampler.sv
// tb_i2c_line_sampler: randomized bus stimulus checked against a pin-level I2C
// protocol model (START/STOP/bit capture rules applied to the driven pins).
module tb_i2c_line_sampler;
  logic clk_i = 1'b0, rstn = 1'b0, clk_en = 1'b0, scl_i = 1'b1, sda_i = 1'b1;
  logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, rx_valid, rx_ack;
  logic [3:0] bit_cnt;
  logic [7:0] rx_byte;
  int checks = 0, failures = 0;
  int n_rise = 0, n_fall = 0, n_start = 0, n_stop = 0;
  int e_rise = 0, e_fall = 0, e_start = 0, e_stop = 0;
  logic [7:0] got_q[$], exp_q[$];
  logic m_open = 1'b0, m_ack = 1'b1;
  int m_cnt = 0;
  logic [7:0] m_sh = '0, m_byte = '0;

  i2c_line_sampler #(.DIV_SAMPLE(4), .FILT_LEN(3)) dut (
    .clk_i(clk_i), .rstn(rstn), .clk_en(clk_en), .scl_i(scl_i), .sda_i(sda_i),
    .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
    .bit_cnt(bit_cnt), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_ack(rx_ack)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    n_rise += int'(scl_rise);
    n_fall += int'(scl_fall);
    n_start += int'(start_det);
    n_stop += int'(stop_det);
    if (rx_valid) got_q.push_back(rx_byte);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wt(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic m_reset();
    m_open = 1'b0;
    m_cnt = 0;
    m_ack = 1'b1;
    m_byte = '0;
  endtask

  task automatic set_sda(input logic v);
    if (v !== sda_i && scl_i) begin
      if (!v) e_start++;
      else e_stop++;
      m_open = !v;
      m_cnt = 0;
    end
    sda_i = v;
  endtask

  task automatic set_scl(input logic v);
    if (v !== scl_i) begin
      if (!v) e_fall++;
      else begin
        e_rise++;
        if (m_open) begin
          if (m_cnt == 8) begin
            m_ack = sda_i;
            m_cnt = 0;
          end else begin
            m_sh = {m_sh[6:0], sda_i};
            m_cnt++;
            if (m_cnt == 8) begin
              m_byte = m_sh;
              exp_q.push_back(m_sh);
            end
          end
        end
      end
    end
    scl_i = v;
  endtask

  task automatic check_state();
    chk("bit_cnt", bit_cnt, m_cnt);
    chk("rx_ack", rx_ack, m_ack);
    chk("rx_byte", rx_byte, m_byte);
    chk("bus_busy", bus_busy, m_open);
    chk("n_rise", n_rise, e_rise);
    chk("n_fall", n_fall, e_fall);
    chk("n_start", n_start, e_start);
    chk("n_stop", n_stop, e_stop);
    chk("rx_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) chk("rx_data", got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic start_c();
    set_sda(1'b1); wt(40);
    set_scl(1'b1); wt(80);
    set_sda(1'b0); wt(80);
    set_scl(1'b0); wt(40);
    check_state();
  endtask

  task automatic stop_c();
    set_sda(1'b0); wt(40);
    set_scl(1'b1); wt(80);
    set_sda(1'b1); wt(80);
    check_state();
  endtask

  task automatic send_bit(input logic b);
    set_sda(b); wt(40);
    set_scl(1'b1); wt(80);
    set_scl(1'b0); wt(40);
    check_state();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic a);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(a);
  endtask

  initial begin
    int len;
    logic [7:0] b;
    // reset values while pins toggle
    for (int i = 0; i < 40; i++) begin
      scl_i = 1'($urandom);
      sda_i = 1'($urandom);
      wt(1);
    end
    chk("rst_scl_f", scl_f, 1);
    chk("rst_sda_f", sda_f, 1);
    chk("rst_strobes", {scl_rise, scl_fall, start_det, stop_det, rx_valid}, 0);
    chk("rst_rx_ack", rx_ack, 1);
    chk("rst_rx_byte", rx_byte, 0);
    chk("rst_bit_cnt", bit_cnt, 0);
    chk("rst_busy", bus_busy, 0);
    scl_i = 1'b1;
    sda_i = 1'b1;
    wt(5);
    rstn = 1'b1;
    clk_en = 1'b1;
    wt(40);
    check_state();

    // short glitches are rejected
    for (int i = 0; i < 4; i++) begin
      len = (i == 0) ? 7 : int'($urandom_range(1, 7));
      scl_i = 1'b0; wt(len); scl_i = 1'b1; wt(60);
      chk("glitch_scl_f", scl_f, 1);
      sda_i = 1'b0; wt(len); sda_i = 1'b1; wt(60);
      chk("glitch_sda_f", sda_f, 1);
    end
    check_state();
    // long pulses are accepted
    for (int i = 0; i < 3; i++) begin
      len = (i == 0) ? 17 : int'($urandom_range(17, 40));
      set_scl(1'b0); wt(len); set_scl(1'b1); wt(60);
      check_state();
    end
    // long SDA pulse with SCL high: START then STOP
    set_sda(1'b0); wt(40); set_sda(1'b1); wt(60);
    check_state();
    // simultaneous change: only SCL edges, no START/STOP
    scl_i = 1'b0; sda_i = 1'b0; e_fall++; wt(60);
    chk("simul_sda_f", sda_f, 0);
    scl_i = 1'b1; sda_i = 1'b1; e_rise++; wt(60);
    check_state();

    // byte receive: 0xA5 ack 0, random bytes, final ack 0
    start_c();
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'($urandom));
    send_byte(8'($urandom), 1'b0);
    stop_c();

    // repeated START after 5 bits, then 0x3C ack 1
    start_c();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    start_c();
    send_byte(8'h3C, 1'b1);
    stop_c();

    // enable gating mid-byte
    b = 8'($urandom);
    start_c();
    for (int i = 7; i >= 5; i--) send_bit(b[i]);
    clk_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      scl_i = ~scl_i;
      wt(25);
      chk("gated_scl_f", scl_f, 0);
    end
    clk_en = 1'b1;
    wt(20);
    check_state();
    for (int i = 4; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b0);
    stop_c();

    // reset mid-byte
    b = 8'($urandom);
    start_c();
    for (int i = 7; i >= 4; i--) send_bit(b[i]);
    rstn = 1'b0;
    #1;
    chk("mid_rst_bit_cnt", bit_cnt, 0);
    chk("mid_rst_busy", bus_busy, 0);
    chk("mid_rst_scl_f", scl_f, 1);
    m_reset();
    wt(5);
    rstn = 1'b1;
    e_fall++;
    wt(40);
    check_state();
    for (int i = 3; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b0);
    stop_c();
    start_c();
    send_byte(8'($urandom), 1'($urandom));
    stop_c();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
